e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
// - Multiply/divide unit in the E stage, beside the ALU; owns the HI/LO registers.
// - Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and MTHI/MTLO in one cycle.
// - Serves MFHI/MFLO reads combinationally.
// - Drives busy so the hazard unit can stall any later MD instruction in D.
// PARAMETERS
// - MULT_CYCLES  5   cycles busy is held after a MULT/MULTU start (>=1)
// - DIV_CYCLES   10  cycles busy is held after a DIV/DIVU start (>=1)
// PORTS
// - clk       in   1   single clock, rising edge
// - reset     in   1   synchronous, active-high
// - srcA      in   32  rs operand (forwarded)
// - srcB      in   32  rt operand (forwarded)
// - mdOp      in   4   operation code, MD_* constants
// - start     in   1   MULT/MULTU/DIV/DIVU issue strobe, one cycle
// - busy      out  1   start | busyReg
// - mdResult  out  32  HI for MD_MFHI, LO for MD_MFLO, else 0
// BEHAVIOUR
// - Clock and reset: one clock domain, clk; reset is synchronous and active-high.
// - Reset: HI=0, LO=0, busyReg=0, counter=0, pending result=0.
//   busy=start during the reset cycle, but that start is discarded.
// - Long-op issue:
//   - Accepted only when start=1, busyReg=0, reset=0, and mdOp is MULT/MULTU/DIV/DIVU.
//   - Accepted in cycle t: operands latched and the 64-bit result computed into a
//     pending register at edge t; counter=N-1; busyReg=1.
//   - N is MULT_CYCLES for multiplies and DIV_CYCLES for divides.
// - Counting: while busyReg, decrement each cycle. On the edge where the counter is 0:
//   - HI/LO <= pending result;
//   - busyReg <= 0.
//   - So busyReg is high for cycles t+1..t+N, and the new HI/LO are visible from t+N+1.
// - Result forms:
//   - MULT: signed 32x32 -> {HI,LO}.
//   - MULTU: unsigned 32x32 -> {HI,LO}.
//   - DIV: LO=quotient, HI=remainder. Signed division truncates toward zero; the
//     remainder takes the sign of the dividend.
//   - DIVU: unsigned quotient and remainder.
// - Divide by zero (srcB=0, DIV/DIVU): busy timing is unchanged; HI/LO keep their old values.
// - Overflow: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. No exception.
// - MTHI/MTLO (start=0):
//   - Write srcA to HI/LO at the next edge when busyReg=0.
//   - Ignored while busyReg=1; the hazard unit must stall these.
// - start while busyReg=1: ignored. The running op is not disturbed and is not restarted.
// - start with a non-long mdOp: ignored, except that busy is still high for that cycle.
// - MFHI/MFLO: mdResult is combinational from the current HI/LO.
//   - The pending result is never forwarded.
//   - Reading during busy returns the old values.
// - Reset mid-operation: the operation is aborted, HI/LO are cleared, and busy drops
//   the next cycle.
// - All arithmetic is 64-bit internally, using $signed casts only for the signed ops.
// STRUCTURE
// - Shared package/header (mips_defs): MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3,
//   MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8, plus MD_OP_W=4.
// - The D-stage hazard unit and the decoder import these constants.
// - One natural sub-module, e_mdu_core: a pure-combinational 64-bit result generator
//   (mdOp, srcA, srcB -> {hi,lo,divZero}).
// - The top level holds the counter, busyReg, pending register and HI/LO.
// TESTING
// - MULT 0xFFFFFFFE x 3: busy is high for 6 cycles (start + 5);
//   MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA from the cycle after busy falls.
// - MULTU 0xFFFFFFFF x 2: HI=1, LO=0xFFFFFFFE.
// - DIV -7 / 2: busy high for 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
// - DIVU 7 / 0 after MTHI 5 / MTLO 9: busy timing is unchanged; HI=5 and LO=9 are kept.
// - start a DIV, then start a MULT at busy cycle 3:
//   - the second start is ignored;
//   - busy still falls after 10 cycles;
//   - the DIV result is retained.
// - Reset asserted in busy cycle 4 of a MULT: the next cycle shows busy=0,
//   MFHI=0 and MFLO=0.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Multiply/divide operation codes shared by the E-stage MDU, the decoder and the hazard unit.
package e_mdu_pkg;

   localparam int MD_OP_W = 4;

   localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
   localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
   localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

   function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational 64-bit multiply/divide result generator producing {hi, lo} and a divide-by-zero flag.
module e_mdu_core
   import e_mdu_pkg::*;
(
   input  logic [MD_OP_W-1:0] mdOp,
   input  logic [31:0]        srcA,
   input  logic [31:0]        srcB,
   output logic [31:0]        hi,
   output logic [31:0]        lo,
   output logic               divZero
);

   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic signed [63:0] sb_safe;
   logic        [31:0] ub_safe;
   logic        [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] quo_s;
   logic        [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   // A zero divisor is replaced by 1 so the dividers never see 0; the flag suppresses the write.
   always_comb begin
      sa      = 64'($signed(srcA));
      sb      = 64'($signed(srcB));
      sb_safe = (srcB == 32'd0) ? 64'sd1 : sb;
      ub_safe = (srcB == 32'd0) ? 32'd1 : srcB;
      prod_s  = sa * sb;
      prod_u  = {32'd0, srcA} * {32'd0, srcB};
      quo_s   = 32'(sa / sb_safe);
      rem_s   = 32'(sa % sb_safe);
      quo_u   = srcA / ub_safe;
      rem_u   = srcA % ub_safe;
   end

   always_comb begin
      hi      = 32'd0;
      lo      = 32'd0;
      divZero = is_div_op(mdOp) && (srcB == 32'd0);
      case (mdOp)
         MD_MULT:  {hi, lo} = prod_s;
         MD_MULTU: {hi, lo} = prod_u;
         MD_DIV:   begin hi = rem_s; lo = quo_s; end
         MD_DIVU:  begin hi = rem_u; lo = quo_u; end
         default:  ;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs long ops over a fixed cycle count, drives busy.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        srcA,
   input  logic [31:0]        srcB,
   input  logic [MD_OP_W-1:0] mdOp,
   input  logic               start,
   output logic               busy,
   output logic [31:0]        mdResult
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

   logic [31:0]      core_hi;
   logic [31:0]      core_lo;
   logic             core_dz;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic             busy_reg;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      pend_p1;
   logic             pend_dz_p1;

   e_mdu_core u_core (
      .mdOp    (mdOp),
      .srcA    (srcA),
      .srcB    (srcB),
      .hi      (core_hi),
      .lo      (core_lo),
      .divZero (core_dz)
   );

   assign busy = start | busy_reg;

   // Issue -> pending register (p1); HI/LO are committed on the edge where cnt reaches 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi         <= 32'd0;
         lo         <= 32'd0;
         busy_reg   <= 1'b0;
         cnt        <= '0;
         pend_p1    <= 64'd0;
         pend_dz_p1 <= 1'b0;
      end else if (busy_reg) begin
         if (cnt == '0) begin
            if (!pend_dz_p1) {hi, lo} <= pend_p1;
            busy_reg <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end else if (start && is_long_op(mdOp)) begin
         pend_p1    <= {core_hi, core_lo};
         pend_dz_p1 <= core_dz;
         busy_reg   <= 1'b1;
         cnt        <= is_div_op(mdOp) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      end else if (!start && mdOp == MD_MTHI) begin
         hi <= srcA;
      end else if (!start && mdOp == MD_MTLO) begin
         lo <= srcA;
      end
   end

   always_comb begin
      mdResult = 32'd0;
      if (mdOp == MD_MFHI) mdResult = hi;
      else if (mdOp == MD_MFLO) mdResult = lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed vector bench for e_mdu: long-op results, busy length and multi-cycle corner sequences.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [31:0]        srcA;
   logic [31:0]        srcB;
   logic [MD_OP_W-1:0] mdOp;
   logic               start;
   logic               busy;
   logic [31:0]        mdResult;

   int n_cmp  = 0;
   int n_fail = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .srcA     (srcA),
      .srcB     (srcB),
      .mdOp     (mdOp),
      .start    (start),
      .busy     (busy),
      .mdResult (mdResult)
   );

   always #5 clk = ~clk;

   typedef struct {
      string              name;
      logic [MD_OP_W-1:0] op;
      logic [31:0]        a;
      logic [31:0]        b;
      int                 busy_cyc;
      logic [31:0]        hi;
      logic [31:0]        lo;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      mdOp = MD_MFHI; #1;
      chk({name, " HI"}, mdResult, exp_hi);
      mdOp = MD_MFLO; #1;
      chk({name, " LO"}, mdResult, exp_lo);
      mdOp = MD_NONE;
   endtask

   // Issues a long op at the next negedge and counts cycles with busy high (start cycle included).
   // inj_at > 0 drives a second MULT start in that busy cycle.
   task automatic run_op(input logic [MD_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, output int cyc);
      @(negedge clk);
      mdOp = op; srcA = a; srcB = b; start = 1'b1;
      cyc = 0;
      #1;
      while (busy && cyc < 64) begin
         cyc++;
         @(negedge clk);
         if (cyc + 1 == inj_at) begin
            mdOp = MD_MULT; srcA = 32'd3; srcB = 32'd3; start = 1'b1;
         end else begin
            mdOp = MD_NONE; start = 1'b0;
         end
         #1;
      end
   endtask

   initial begin
      int cyc;
      vecs[0] = '{"mult_neg2x3",   MD_MULT,  32'hFFFFFFFE, 32'd3,        6,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{"multu_max_x2",  MD_MULTU, 32'hFFFFFFFF, 32'd2,        6,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{"div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        11, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{"divu_100_7",    MD_DIVU,  32'd100,      32'd7,        11, 32'd2,        32'd14};
      vecs[4] = '{"div_overflow",  MD_DIV,   32'h80000000, 32'hFFFFFFFF, 11, 32'h00000000, 32'h80000000};
      vecs[5] = '{"mult_maxpos",   MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 6,  32'h3FFFFFFF, 32'h00000001};
      vecs[6] = '{"div_7_m2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 11, 32'h00000001, 32'hFFFFFFFD};
      vecs[7] = '{"multu_2p31sq",  MD_MULTU, 32'h80000000, 32'h80000000, 6,  32'h40000000, 32'h00000000};
      vecs[8] = '{"mult_m5x7",     MD_MULT,  32'hFFFFFFFB, 32'd7,        6,  32'hFFFFFFFF, 32'hFFFFFFDD};

      // Reset with a start pending: busy follows start, but the op is dropped.
      reset = 1'b1; start = 1'b1; mdOp = MD_MULT; srcA = 32'd2; srcB = 32'd3;
      #1;
      chk("busy_during_reset", {31'd0, busy}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; start = 1'b0; mdOp = MD_NONE;
      #1;
      chk("busy_after_reset", {31'd0, busy}, 32'd0);
      read_hilo("reset", 32'd0, 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, cyc);
         chk({vecs[i].name, " busy_cycles"}, 32'(cyc), 32'(vecs[i].busy_cyc));
         read_hilo(vecs[i].name, vecs[i].hi, vecs[i].lo);
      end

      // MTHI/MTLO, then DIVU by zero keeps them.
      @(negedge clk);
      mdOp = MD_MTHI; srcA = 32'd5; start = 1'b0;
      @(negedge clk);
      mdOp = MD_MTLO; srcA = 32'd9;
      @(negedge clk);
      mdOp = MD_NONE; srcA = 32'd0;
      read_hilo("mthi_mtlo", 32'd5, 32'd9);
      run_op(MD_DIVU, 32'd7, 32'd0, 0, cyc);
      chk("divu_by_zero busy_cycles", 32'(cyc), 32'd11);
      read_hilo("divu_by_zero", 32'd5, 32'd9);

      // Second start in busy cycle 3 of a DIV is ignored.
      run_op(MD_DIV, 32'd100, 32'd7, 3, cyc);
      chk("div_then_mult busy_cycles", 32'(cyc), 32'd11);
      read_hilo("div_then_mult", 32'd2, 32'd14);

      // MTLO during busy is ignored; MFLO during busy returns the old value; reset aborts.
      @(negedge clk);
      mdOp = MD_MULT; srcA = 32'd6; srcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mdOp = MD_MTLO; srcA = 32'hDEADBEEF;
      @(negedge clk);
      mdOp = MD_MFLO; #1;
      chk("mflo_during_busy", mdResult, 32'd14);
      chk("busy_mid_mult", {31'd0, busy}, 32'd1);
      @(negedge clk);
      mdOp = MD_NONE; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; #1;
      chk("busy_after_abort", {31'd0, busy}, 32'd0);
      read_hilo("abort", 32'd0, 32'd0);

      // Non-long start: busy for that cycle only, no effect on HI/LO.
      @(negedge clk);
      start = 1'b1; mdOp = MD_MTHI; srcA = 32'd77; #1;
      chk("busy_nonlong_start", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0; mdOp = MD_NONE; #1;
      chk("busy_after_nonlong", {31'd0, busy}, 32'd0);
      chk("mdresult_none", mdResult, 32'd0);
      read_hilo("nonlong_start", 32'd0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
